// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pkg
//  Brief    : Shared encodings for the unified-memory port arbiter: FSM
//             states, access-owner codes and default bus widths.
//  Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int ARB_AW = 16;
  localparam int ARB_DW = 16;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // Owner of the access currently latched in the command registers
  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_LDR  = 1'b1;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Shares one single-port fixed-latency memory between the core's
//             fetch/load/store strobes and an external loader/debug port.
//             One access at a time: grant, ACCESS for WAIT_CYCLES+1 cycles,
//             one RESP cycle carrying the owner's completion pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW          = ARB_AW,
  parameter int DW          = ARB_DW,
  parameter int WAIT_CYCLES = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // core side
  input  logic          core_im_rd,
  input  logic          core_dm_rd,
  input  logic          core_dm_wr,
  input  logic [AW-1:0] core_iaddr,
  input  logic [AW-1:0] core_daddr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_done,
  output logic          core_stall,
  // loader side
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // status
  output logic          err_multi
);

  // Starvation counter must hold STARVE_MAX; keep at least one bit so a
  // zero limit still yields a legal vector.
  localparam int               SW            = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]    c_starve_max  = SW'(STARVE_MAX);
  localparam logic [3:0]       c_wait_init   = 4'(WAIT_CYCLES);

  arb_state_t    r_state;
  arb_state_t    w_next_state;

  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_wait_cnt;
  logic [SW-1:0] r_starve_cnt;
  logic [DW-1:0] r_core_rdata;
  logic [DW-1:0] r_ldr_rdata;
  logic          r_err_multi;

  logic          w_core_req;
  logic          w_ldr_wins;
  logic          w_grant_core;
  logic          w_grant_ldr;
  logic          w_core_we;
  logic [AW-1:0] w_core_addr;
  logic          w_core_multi;
  logic          w_access_last;

  // Core command decode: store beats load beats fetch; data accesses use
  // the ALU address, fetch uses the PC.
  assign w_core_req   = core_im_rd | core_dm_rd | core_dm_wr;
  assign w_core_we    = core_dm_wr;
  assign w_core_addr  = (core_dm_wr | core_dm_rd) ? core_daddr : core_iaddr;
  assign w_core_multi = (core_im_rd & core_dm_rd) | (core_im_rd & core_dm_wr)
                      | (core_dm_rd & core_dm_wr);

  // Core has priority until the loader has waited through STARVE_MAX core
  // grants; an idle core never blocks the loader.
  assign w_ldr_wins    = ldr_req && (r_starve_cnt >= c_starve_max);
  assign w_grant_ldr   = (r_state == IDLE) && (w_ldr_wins || (ldr_req && !w_core_req));
  assign w_grant_core  = (r_state == IDLE) && w_core_req && !w_ldr_wins;
  assign w_access_last = (r_state == ACCESS) && (r_wait_cnt == 4'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant_core || w_grant_ldr) w_next_state = ACCESS;
      ACCESS:  if (r_wait_cnt == 4'd0)          w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Latch the winning command at grant so requester operand changes during
  // the access cannot disturb the memory bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_CORE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant_ldr) begin
      r_owner <= OWN_LDR;
      r_we    <= ldr_we;
      r_addr  <= ldr_addr;
      r_wdata <= ldr_wdata;
    end else if (w_grant_core) begin
      r_owner <= OWN_CORE;
      r_we    <= w_core_we;
      r_addr  <= w_core_addr;
      r_wdata <= core_wdata;
    end
  end

  // Memory latency counter: loaded at grant, counts down through ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if (w_grant_core || w_grant_ldr) begin
      r_wait_cnt <= c_wait_init;
    end else if ((r_state == ACCESS) && (r_wait_cnt != 4'd0)) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  // Capture read data into the owner's register on the last ACCESS cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_rdata <= '0;
      r_ldr_rdata  <= '0;
    end else if (w_access_last && !r_we) begin
      if (r_owner == OWN_LDR) begin
        r_ldr_rdata  <= mem_rdata;
      end else begin
        r_core_rdata <= mem_rdata;
      end
    end
  end

  // Count core grants the loader has sat through; any idle loader cycle or
  // loader grant restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!ldr_req || w_grant_ldr) begin
      r_starve_cnt <= '0;
    end else if (w_grant_core && (r_starve_cnt < c_starve_max)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Sticky flag for overlapping core strobes seen at a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_multi <= 1'b0;
    end else if (w_grant_core && w_core_multi) begin
      r_err_multi <= 1'b1;
    end
  end

  assign mem_en     = (r_state == ACCESS);
  assign mem_we     = mem_en && r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign core_done  = (r_state == RESP) && (r_owner == OWN_CORE);
  assign ldr_ack    = (r_state == RESP) && (r_owner == OWN_LDR);
  assign core_stall = w_core_req && !core_done;
  assign core_rdata = r_core_rdata;
  assign ldr_rdata  = r_ldr_rdata;
  assign err_multi  = r_err_multi;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Directed self-checking bench for mem_port_arbiter. Two DUTs
//             share stimulus: u_dut (STARVE_MAX=4) on a latency-accurate
//             memory model, u_dut0 (STARVE_MAX=0) on a constant-data memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_im_rd, core_dm_rd, core_dm_wr;
  logic [15:0] core_iaddr, core_daddr, core_wdata;
  logic        ldr_req, ldr_we;
  logic [15:0] ldr_addr, ldr_wdata;

  // u_dut outputs
  logic [15:0] core_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        core_done, core_stall, ldr_ack, mem_en, mem_we, err_multi;
  // u_dut0 outputs
  logic [15:0] core_rdata0, ldr_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic        core_done0, core_stall0, ldr_ack0, mem_en0, mem_we0, err_multi0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .core_im_rd(core_im_rd), .core_dm_rd(core_dm_rd), .core_dm_wr(core_dm_wr),
    .core_iaddr(core_iaddr), .core_daddr(core_daddr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_done(core_done), .core_stall(core_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_multi(err_multi)
  );

  mem_port_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(1), .STARVE_MAX(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .core_im_rd(core_im_rd), .core_dm_rd(core_dm_rd), .core_dm_wr(core_dm_wr),
    .core_iaddr(core_iaddr), .core_daddr(core_daddr), .core_wdata(core_wdata),
    .core_rdata(core_rdata0), .core_done(core_done0), .core_stall(core_stall0),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata0), .ldr_ack(ldr_ack0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .err_multi(err_multi0)
  );

  // Memory model for u_dut: data is only valid on the second enabled cycle
  // (WAIT_CYCLES=1); any other cycle returns a poison pattern.
  logic [15:0] mem [0:255];
  logic [3:0]  en_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_cnt   <= 4'd0;
      mem[4]   <= 16'h1234;
      mem[16]  <= 16'h0000;
      mem[48]  <= 16'hCAFE;
    end else begin
      en_cnt <= mem_en ? en_cnt + 4'd1 : 4'd0;
      if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  assign mem_rdata  = (mem_en && en_cnt == 4'd1) ? mem[mem_addr[7:0]] : 16'hDEAD;
  assign mem_rdata0 = 16'h5A5A;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drop_all();
    core_im_rd = 1'b0; core_dm_rd = 1'b0; core_dm_wr = 1'b0;
    ldr_req    = 1'b0; ldr_we     = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          n0_l;
    int          n0_c;
    int          pulses;
    logic [9:0]  seq;

    rst_n = 1'b0;
    core_im_rd = 1'b0; core_dm_rd = 1'b0; core_dm_wr = 1'b0;
    core_iaddr = 16'h0; core_daddr = 16'h0; core_wdata = 16'h0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 16'h0; ldr_wdata = 16'h0;
    #1;
    // ---- reset state
    chk("rst_mem_en",     mem_en,     0);
    chk("rst_core_done",  core_done,  0);
    chk("rst_ldr_ack",    ldr_ack,    0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_err_multi",  err_multi,  0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // ---- fetch from 0x0004, data 0x1234
    core_im_rd = 1'b1; core_iaddr = 16'h0004;
    #1 chk("fetch_stall_req", core_stall, 1);
    tick();
    chk("fetch_en1",   mem_en,   1);
    chk("fetch_addr",  mem_addr, 16'h0004);
    chk("fetch_we",    mem_we,   0);
    tick();
    chk("fetch_en2",   mem_en,    1);
    chk("fetch_done2", core_done, 0);
    tick();
    chk("fetch_done",  core_done,  1);
    chk("fetch_en3",   mem_en,     0);
    chk("fetch_rdata", core_rdata, 16'h1234);
    chk("fetch_stall", core_stall, 0);
    core_im_rd = 1'b0;
    tick();
    chk("fetch_done_pulse", core_done, 0);

    // ---- store 0xBEEF to 0x0010
    core_dm_wr = 1'b1; core_daddr = 16'h0010; core_wdata = 16'hBEEF;
    tick();
    chk("st_we1",    mem_we,    1);
    chk("st_addr1",  mem_addr,  16'h0010);
    chk("st_wdata1", mem_wdata, 16'hBEEF);
    tick();
    chk("st_we2",    mem_we,    1);
    chk("st_wdata2", mem_wdata, 16'hBEEF);
    tick();
    chk("st_done",   core_done,  1);
    chk("st_rdata",  core_rdata, 16'h1234);
    core_dm_wr = 1'b0;
    tick();

    // ---- load 0x0010, operands changed after grant
    core_dm_rd = 1'b1; core_daddr = 16'h0010;
    tick();
    core_daddr = 16'h0020;
    tick();
    chk("ld_latched_addr", mem_addr, 16'h0010);
    tick();
    chk("ld_done",  core_done,  1);
    chk("ld_rdata", core_rdata, 16'hBEEF);
    core_dm_rd = 1'b0;
    tick();

    // ---- continuous core + loader contention
    core_im_rd = 1'b1; core_iaddr = 16'h0004;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0030;
    n = 0; n0_l = 0; n0_c = 0; seq = '0;
    for (int cyc = 0; cyc < 100 && n < 10; cyc++) begin
      tick();
      if (ldr_ack0)  n0_l++;
      if (core_done0) n0_c++;
      if (core_done || ldr_ack) begin
        seq[n] = ldr_ack;
        n++;
      end
    end
    chk("starve_count", n, 10);
    chk("starve_seq",   seq, 10'b1000010000);
    chk("starve_ldr_rdata",  ldr_rdata,  16'hCAFE);
    chk("starve_core_rdata", core_rdata, 16'h1234);
    chk("starve0_ldr_acks",  n0_l, 10);
    chk("starve0_core_done", n0_c, 0);
    chk("starve0_stall",     core_stall0, 1);
    drop_all();

    // ---- STARVE_MAX=0: loader write first, then core load
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0040; ldr_wdata = 16'h7777;
    core_dm_rd = 1'b1; core_daddr = 16'h0030;
    tick();
    chk("s0_mem_we",    mem_we0,    1);
    chk("s0_mem_addr",  mem_addr0,  16'h0040);
    chk("s0_mem_wdata", mem_wdata0, 16'h7777);
    tick();
    tick();
    chk("s0_ldr_ack",   ldr_ack0,    1);
    chk("s0_core_wait", core_done0,  0);
    chk("s0_stall",     core_stall0, 1);
    chk("s0_ldr_rdata_kept", ldr_rdata0, 16'h5A5A);
    ldr_req = 1'b0; ldr_we = 1'b0;
    tick();
    chk("s0_ack_pulse", ldr_ack0, 0);
    tick();
    chk("s0_core_addr", mem_addr0, 16'h0030);
    tick();
    chk("s0_stall_hold", core_stall0, 1);
    tick();
    chk("s0_core_done",  core_done0,  1);
    chk("s0_core_rdata", core_rdata0, 16'h5A5A);
    chk("s0_stall_off",  core_stall0, 0);
    drop_all();

    // ---- two strobes at grant: data read wins, sticky error
    chk("multi_pre", err_multi, 0);
    core_im_rd = 1'b1; core_dm_rd = 1'b1;
    core_iaddr = 16'h0004; core_daddr = 16'h0010;
    tick();
    chk("multi_addr", mem_addr,  16'h0010);
    chk("multi_err",  err_multi, 1);
    tick();
    tick();
    chk("multi_done",  core_done,  1);
    chk("multi_rdata", core_rdata, 16'hBEEF);
    core_im_rd = 1'b0; core_dm_rd = 1'b0;
    tick();
    core_im_rd = 1'b1; core_iaddr = 16'h0004;
    repeat (3) tick();
    chk("clean_done",   core_done,  1);
    chk("clean_rdata",  core_rdata, 16'h1234);
    chk("multi_sticky", err_multi,  1);
    drop_all();

    // ---- asynchronous reset in the middle of ACCESS
    core_dm_rd = 1'b1; core_daddr = 16'h0030;
    tick();
    chk("arst_pre_en", mem_en, 1);
    #3;
    rst_n = 1'b0;
    core_dm_rd = 1'b0;
    #1;
    chk("arst_mem_en",     mem_en,     0);
    chk("arst_mem_addr",   mem_addr,   0);
    chk("arst_core_rdata", core_rdata, 0);
    chk("arst_ldr_rdata",  ldr_rdata,  0);
    chk("arst_err_multi",  err_multi,  0);
    chk("arst_core_done",  core_done,  0);
    tick();
    tick();
    #3;
    rst_n = 1'b1;
    pulses = 0;
    repeat (4) begin
      tick();
      if (core_done || ldr_ack) pulses++;
    end
    chk("arst_no_pulse", pulses, 0);
    chk("arst_idle_en",  mem_en, 0);
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0030;
    repeat (3) tick();
    chk("arst_ldr_ack",   ldr_ack,   1);
    chk("arst_ldr_rdata", ldr_rdata, 16'hCAFE);
    ldr_req = 1'b0;
    tick();
    chk("arst_ack_pulse", ldr_ack, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
